line_mem_responder: RTL and testbench

- Synthesizable responder for the 128-bit line-wide memory interface driven by the I-cache and D-cache: mem_read/mem_write, mem_addr[31:4], mem_wdata, mem_rdata, mem_ready.
- Stores whole cache lines, services one request at a time after a programmable latency, and returns a single-cycle mem_ready pulse.
- Replaces the behavioural slow memory in FPGA/emulation builds, and flags requester-side protocol violations.

---
 rtl/line_mem_pkg.sv | 7 +
 rtl/line_mem_store.sv | 25 ++
 rtl/line_mem_responder.sv | 76 +++++++
 tb/tb_line_mem_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/line_mem_pkg.sv
// line_mem_pkg: shared state encoding and width constants for the line memory responder.
package line_mem_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
    localparam int LINE_ADDR_W = 28;
    localparam int LINE_W = 128;
    localparam int CNT_W = 4;
endpackage

// File: rtl/line_mem_store.sv
// line_mem_store: line storage with one synchronous write port and one registered read port.
module line_mem_store
    import line_mem_pkg::*;
#(
    parameter int IDX_W = 8,
    parameter int DATA_W = LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [2**IDX_W];
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_idx] <= i_wdata;
    end
    // Only the read register is reset; line contents survive reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) o_rdata <= '0;
        else if (i_re) o_rdata <= r_mem[i_idx];
    end
endmodule

// File: rtl/line_mem_responder.sv
// line_mem_responder: line-wide memory slave with programmable latency, one-cycle ready
// pulse, sticky requester protocol-violation flag and a saturating completion counter.
module line_mem_responder
    import line_mem_pkg::*;
#(
    parameter int ADDR_W = LINE_ADDR_W,
    parameter int DATA_W = LINE_W,
    parameter int IDX_W = 8,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              proto_err,
    output logic [15:0]       req_cnt
);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);
    state_t              r_state, w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_wr, r_err;
    logic [15:0]         r_req_cnt;
    logic                w_req, w_fire, w_viol;
    assign w_req = mem_read | mem_write;
    always_comb begin
        w_next = (r_state == IDLE) ? (w_req ? BUSY : IDLE) :
                 (r_state == BUSY) ? ((r_cnt == '0) ? RESP : BUSY) : IDLE;
        w_fire = (r_state == BUSY) && (r_cnt == '0);
        w_viol = ((r_state == IDLE) && mem_read && mem_write) ||
                 ((r_state == BUSY) && ((mem_addr != r_addr) || !w_req));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wr      <= 1'b0;
            r_err     <= 1'b0;
            r_req_cnt <= '0;
        end else begin
            if (r_state == IDLE && w_req) begin
                r_addr  <= mem_addr;
                r_wdata <= mem_wdata;
                r_wr    <= mem_write;
                r_cnt   <= LAT_M1;
            end else if (r_state == BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_viol) r_err <= 1'b1;
            if (r_state == RESP && r_req_cnt != 16'hFFFF) r_req_cnt <= r_req_cnt + 16'd1;
        end
    end
    // The access fires on the BUSY->RESP edge, so an aborted request never commits.
    line_mem_store #(.IDX_W(IDX_W), .DATA_W(DATA_W)) u_store (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_fire && r_wr),
        .i_re    (w_fire && !r_wr),
        .i_idx   (r_addr[IDX_W-1:0]),
        .i_wdata (r_wdata),
        .o_rdata (mem_rdata)
    );
    assign mem_ready = (r_state == RESP);
    assign proto_err = r_err;
    assign req_cnt   = r_req_cnt;
endmodule

// File: tb/tb_line_mem_responder.sv
// tb_line_mem_responder: two responders (latency 4 and 1) checked every cycle against a
// timeline-based transaction model, plus directed literal checks.
module tb_line_mem_responder;
    logic clk = 1'b0, rst = 1'b1;
    logic rd [2], wr [2];
    logic [27:0] addr [2];
    logic [127:0] wdata [2], o_rdata [2];
    logic o_ready [2], o_err [2];
    logic [15:0] o_cnt [2];
    int n = 0, cmp = 0, errs = 0;
    int lat [2] = '{4, 1};
    bit act [2], lwr [2], e_rdy [2], e_err [2], e_rk [2];
    int acc [2], e_cnt [2];
    logic [27:0] la [2];
    logic [127:0] lw [2], e_rdata [2];
    logic [127:0] mm [2][256];
    bit mv [2][256];
    localparam logic [127:0] DB = 128'hDEADBEEF_00000001_00000002_00000003;
    localparam logic [127:0] DA = 128'hAAAA0000_11112222_33334444_55556666;
    localparam logic [127:0] DBB = 128'hBBBB0000_BBBB1111_BBBB2222_BBBB3333;
    localparam logic [127:0] DC = 128'hCCCC0000_CCCC1111_CCCC2222_CCCC3333;
    localparam logic [127:0] DD = 128'hDDDD0000_DDDD1111_DDDD2222_DDDD3333;
    localparam logic [127:0] DE = 128'hEEEE0000_EEEE1111_EEEE2222_EEEE3333;
    localparam logic [127:0] DF = 128'hFFFF0000_FFFF1111_FFFF2222_FFFF3333;

    always #5 clk = ~clk;

    line_mem_responder #(.LATENCY(4)) dut0 (
        .clk(clk), .rst(rst), .mem_read(rd[0]), .mem_write(wr[0]), .mem_addr(addr[0]),
        .mem_wdata(wdata[0]), .mem_rdata(o_rdata[0]), .mem_ready(o_ready[0]),
        .proto_err(o_err[0]), .req_cnt(o_cnt[0]));
    line_mem_responder #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .mem_read(rd[1]), .mem_write(wr[1]), .mem_addr(addr[1]),
        .mem_wdata(wdata[1]), .mem_rdata(o_rdata[1]), .mem_ready(o_ready[1]),
        .proto_err(o_err[1]), .req_cnt(o_cnt[1]));

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        cmp++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // Model: a request accepted at edge A completes at edge A+L (ready visible after it),
    // retires at edge A+L+1 (counter bumps), and the next acceptance is possible afterwards.
    always @(posedge clk) begin
        n++;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                act[d] = 0; e_rdy[d] = 0; e_cnt[d] = 0; e_err[d] = 0;
                e_rdata[d] = '0; e_rk[d] = 1;
            end else begin
                if (act[d] && n > acc[d] && n <= acc[d] + lat[d] &&
                    (addr[d] != la[d] || !(rd[d] || wr[d]))) e_err[d] = 1;
                if (act[d] && n == acc[d] + lat[d]) begin
                    if (lwr[d]) begin
                        mm[d][la[d][7:0]] = lw[d];
                        mv[d][la[d][7:0]] = 1;
                    end else begin
                        e_rdata[d] = mm[d][la[d][7:0]];
                        e_rk[d] = mv[d][la[d][7:0]];
                    end
                end
                if (act[d] && n == acc[d] + lat[d] + 1) begin
                    act[d] = 0;
                    if (e_cnt[d] < 65535) e_cnt[d]++;
                end else if (!act[d] && (rd[d] || wr[d])) begin
                    act[d] = 1; acc[d] = n; la[d] = addr[d]; lw[d] = wdata[d]; lwr[d] = wr[d];
                    if (rd[d] && wr[d]) e_err[d] = 1;
                end
                e_rdy[d] = act[d] && n == acc[d] + lat[d];
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("ready%0d", d), 128'(o_ready[d]), 128'(e_rdy[d]));
            chk($sformatf("proto_err%0d", d), 128'(o_err[d]), 128'(e_err[d]));
            chk($sformatf("req_cnt%0d", d), 128'(o_cnt[d]), 128'(e_cnt[d]));
            if (e_rk[d]) chk($sformatf("rdata%0d", d), o_rdata[d], e_rdata[d]);
        end
    end

    task automatic wait_ready(input int d, output int e);
        e = -1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #2;
            if (o_ready[d]) begin
                e = n;
                break;
            end
        end
        if (e < 0) begin
            cmp++; errs++;
            $display("FAIL timeout%0d: got no mem_ready expected one within 40 cycles", d);
        end
    endtask

    task automatic xact(input int d, input bit w, input bit r, input logic [27:0] a,
                        input logic [127:0] wd, input int viol, input bit hold,
                        output int ae, output int re);
        @(negedge clk);
        wr[d] = w; rd[d] = r; addr[d] = a; wdata[d] = wd;
        @(posedge clk); #2;
        ae = n;
        if (viol == 1) begin
            @(negedge clk); addr[d] = a ^ 28'h1;
        end else if (viol == 2) begin
            @(negedge clk); wr[d] = 0; rd[d] = 0;
        end
        wait_ready(d, re);
        if (!hold) begin
            @(negedge clk); wr[d] = 0; rd[d] = 0;
        end
    endtask

    initial begin
        int ae, re, r2, r3;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 0; wr[d] = 0; addr[d] = '0; wdata[d] = '0;
        end
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        chk("rst_rdata", o_rdata[0], 128'd0);
        chk("rst_ready", 128'(o_ready[0]), 128'd0);
        chk("rst_err", 128'(o_err[0]), 128'd0);
        chk("rst_cnt", 128'(o_cnt[0]), 128'd0);

        xact(0, 1, 0, 28'h0000010, DB, 0, 0, ae, re);
        chk("lat4", 128'(re - ae), 128'd4);
        @(posedge clk); #2;
        chk("cnt_after_wr", 128'(o_cnt[0]), 128'd1);
        chk("err_after_wr", 128'(o_err[0]), 128'd0);

        xact(0, 0, 1, 28'h0000010, '0, 0, 0, ae, re);
        chk("rd_data", o_rdata[0], DB);
        repeat (10) @(posedge clk);
        #2;
        chk("rd_hold", o_rdata[0], DB);
        chk("cnt_after_rd", 128'(o_cnt[0]), 128'd2);

        xact(0, 1, 0, 28'h0000105, DA, 0, 0, ae, re);
        xact(0, 0, 1, 28'h0000005, '0, 0, 0, ae, re);
        chk("alias", o_rdata[0], DA);

        xact(0, 1, 1, 28'h0000020, DBB, 0, 0, ae, re);
        chk("both_err", 128'(o_err[0]), 128'd1);
        xact(0, 0, 1, 28'h0000020, '0, 0, 0, ae, re);
        chk("both_is_write", o_rdata[0], DBB);
        chk("err_sticky", 128'(o_err[0]), 128'd1);

        xact(0, 1, 0, 28'h0000030, DC, 0, 0, ae, re);
        @(negedge clk);
        wr[0] = 1; addr[0] = 28'h0000030; wdata[0] = DD;
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        #1;
        chk("rst_async_cnt", 128'(o_cnt[0]), 128'd0);
        chk("rst_async_err", 128'(o_err[0]), 128'd0);
        wr[0] = 0;
        @(negedge clk);
        rst = 0;
        repeat (6) @(posedge clk);
        #2;
        chk("rst_no_ready_cnt", 128'(o_cnt[0]), 128'd0);
        xact(0, 0, 1, 28'h0000030, '0, 0, 0, ae, re);
        chk("abort_no_commit", o_rdata[0], DC);

        for (int i = 0; i < 60; i++) begin
            int v = $urandom_range(0, 7);
            bit w = 1'($urandom_range(0, 1));
            logic [27:0] a = {20'($urandom), 8'($urandom_range(0, 7))};
            logic [127:0] wd = {$urandom, $urandom, $urandom, $urandom};
            xact(0, w || v == 2, !w || v == 2, a, wd, v < 2 ? v + 1 : 0, 0, ae, re);
        end

        xact(1, 1, 0, 28'h0000040, DE, 0, 0, ae, re);
        xact(1, 0, 1, 28'h0000040, '0, 0, 1, ae, re);
        chk("b2b_data", o_rdata[1], DE);
        wait_ready(1, r2);
        chk("b2b_gap1", 128'(r2 - re), 128'd3);
        wait_ready(1, r3);
        chk("b2b_gap2", 128'(r3 - r2), 128'd3);
        @(negedge clk);
        rd[1] = 0;
        chk("b2b_err", 128'(o_err[1]), 128'd0);
        xact(1, 1, 0, 28'h0000041, DF, 0, 0, ae, re);
        xact(1, 0, 1, 28'h0000040, '0, 1, 0, ae, re);
        chk("latched_addr", o_rdata[1], DE);
        chk("addr_chg_err", 128'(o_err[1]), 128'd1);

        repeat (3) @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
